// File: rtl/fifo_read_ctrl_if.sv
// fifo_read_ctrl_if: bundles the memory-side and stream-side signals of the
// FIFO read controller. The controller connects through the master modport;
// the memory/consumer environment connects through the slave modport.
// Optional build macro: FIFO_RD_ALMOST_EMPTY_EN adds the almost_empty status.
interface fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 16
);
  localparam int AW = $clog2(ADDR_SIZE);
  localparam int CW = $clog2(ADDR_SIZE + 1);

  logic                  wr_pulse;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [AW-1:0]         read_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  overflow;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic                  almost_empty;
`endif

  modport master (
    input  wr_pulse,
    input  mem_data,
    input  out_ready,
    output read_addr,
    output out_data,
    output out_valid,
    output empty,
    output count,
    output overflow
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    , output almost_empty
`endif
  );

  modport slave (
    output wr_pulse,
    output mem_data,
    output out_ready,
    input  read_addr,
    input  out_data,
    input  out_valid,
    input  empty,
    input  count,
    input  overflow
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    , input  almost_empty
`endif
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller placed directly after the FIFO memory.
// Counts stored words from the memory write strobe, drives the memory read
// address, and registers the memory's combinational read data into a single
// output register presented on a valid/ready stream.
// Optional build macro: FIFO_RD_ALMOST_EMPTY_EN adds a registered almost_empty
// output (and the AE_LEVEL parameter); without it neither exists.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 16
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  , parameter int AE_LEVEL = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  fifo_read_ctrl_if.master  bus
);
  localparam int AW = $clog2(ADDR_SIZE);
  localparam int CW = $clog2(ADDR_SIZE + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDR_SIZE - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(ADDR_SIZE);
  localparam logic [CW-1:0] ZERO_CNT  = {CW{1'b0}};

  // The output register is either holding an unconsumed word or not.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]         read_addr_q, read_addr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  empty_q, empty_d;
  logic                  load_s;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam int EW = CW + 1;
  logic                  almost_empty_q, almost_empty_d;
`endif

  // Next-state logic: output-stage FSM, read pointer, occupancy and status.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    read_addr_d = read_addr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    load_s      = 1'b0;

    // A word moves from memory into the output register whenever one is
    // stored and the register is free or being consumed this cycle.
    case (state_q)
      ST_EMPTY: begin
        if (count_q != ZERO_CNT) begin
          load_s  = 1'b1;
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          if (count_q != ZERO_CNT) begin
            load_s  = 1'b1;
            state_d = ST_FULL;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Capture memory data and advance the read pointer, wrapping at depth
    // (depth need not be a power of two).
    if (load_s) begin
      out_data_d  = bus.mem_data;
      read_addr_d = (read_addr_q == LAST_ADDR) ? {AW{1'b0}} : (read_addr_q + AW'(1));
    end else begin
      out_data_d  = out_data_q;
      read_addr_d = read_addr_q;
    end

    // A write while full with nothing leaving is lost: count saturates and
    // the sticky overflow flag is raised. Write plus load cancels out.
    case ({bus.wr_pulse, load_s})
      2'b10: begin
        if (count_q == FULL_CNT) begin
          count_d    = count_q;
          overflow_d = 1'b1;
        end else begin
          count_d    = count_q + CW'(1);
        end
      end
      2'b01: begin
        count_d = count_q - CW'(1);
      end
      default: begin
        count_d = count_q;
      end
    endcase

    // Status flags are registered from next-state values so they line up
    // with the count and out_valid they describe.
    empty_d = (count_d == ZERO_CNT) && (state_d == ST_EMPTY);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    almost_empty_d = ((EW'(count_d) + EW'(state_d == ST_FULL)) <= EW'(AE_LEVEL));
`endif
  end

  // State registers; reset discards any word held in the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      read_addr_q <= {AW{1'b0}};
      count_q     <= ZERO_CNT;
      overflow_q  <= 1'b0;
      empty_q     <= 1'b1;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      almost_empty_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      read_addr_q <= read_addr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      empty_q     <= empty_d;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      almost_empty_q <= almost_empty_d;
`endif
    end
  end

  assign bus.read_addr = read_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  assign bus.almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: drives fifo_read_ctrl with a behavioural 16x8 memory.
// Every written word is queued as the expected output; a monitor pops and
// compares on each stream transfer. Directed checks cover status outputs.
module tb_fifo_read_ctrl;
  localparam int DW = 8;
  localparam int AS = 16;

  logic clk;
  logic rst;
  logic mem_we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [AS];
  logic [3:0] wr_ptr;
  logic [DW-1:0] exp_q [$];
  int checks;
  int failures;

  fifo_read_ctrl_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AS)) bus ();

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AS), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.master));
`else
  fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AS)) dut (
    .clk(clk), .rst(rst), .bus(bus.master));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 4'd0;
    end else if (bus.wr_pulse && mem_we) begin
      mem[wr_ptr] <= wdata;
      wr_ptr      <= wr_ptr + 4'd1;
    end
  end
  assign bus.mem_data = mem[bus.read_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One wr_pulse cycle; real_write=0 pulses the strobe without storing data.
  task automatic wr(input logic [DW-1:0] d, input bit real_write);
    bus.wr_pulse = 1'b1;
    mem_we       = real_write;
    wdata        = d;
    if (real_write) exp_q.push_back(d);
    tick();
  endtask

  task automatic wr_idle();
    bus.wr_pulse = 1'b0;
    mem_we       = 1'b0;
  endtask

  // Consume until empty, optionally toggling out_ready; bounded.
  task automatic drain(input string name, input int bound, input bit toggle);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (!bus.empty && n < bound) begin
      tick();
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      chk("almost_empty", 32'(bus.almost_empty), 32'(exp_q.size() <= 2));
`endif
      if (toggle) bus.out_ready = ~bus.out_ready;
      n++;
    end
    chk(name, 32'(bus.empty), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  // Scoreboard monitor: a transfer happens at the next posedge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(bus.out_data), 32'hFFFF_FFFF);
      end else begin
        chk("stream_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.wr_pulse = 1'b0;
    bus.out_ready = 1'b0;
    mem_we = 1'b0;
    wdata = 8'h00;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_addr", 32'(bus.read_addr), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
`endif
    rst = 1'b0;
    tick();

    // Single word with backpressure, latency and hold.
    wr(8'hA5, 1'b1);
    wr_idle();
    chk("single_cnt1", 32'(bus.count), 32'd1);
    chk("single_valid_n1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("single_valid_n2", 32'(bus.out_valid), 32'd1);
    chk("single_data", 32'(bus.out_data), 32'hA5);
    chk("single_empty0", 32'(bus.empty), 32'd0);
    chk("single_cnt0", 32'(bus.count), 32'd0);
    chk("single_addr", 32'(bus.read_addr), 32'd1);
    tick();
    tick();
    chk("single_hold_v", 32'(bus.out_valid), 32'd1);
    chk("single_hold_d", 32'(bus.out_data), 32'hA5);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("single_done_v", 32'(bus.out_valid), 32'd0);
    chk("single_done_e", 32'(bus.empty), 32'd1);
    chk("single_keep_d", 32'(bus.out_data), 32'hA5);

    // Streaming 0..15 with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr(8'(i), 1'b1);
      if (i >= 1) chk("stream_no_gap", 32'(bus.out_valid), 32'd1);
    end
    wr_idle();
    chk("stream_wrap_addr", 32'(bus.read_addr), 32'd0);
    chk("stream_cnt1", 32'(bus.count), 32'd1);
    tick();
    chk("stream_last_v", 32'(bus.out_valid), 32'd1);
    chk("stream_last_d", 32'(bus.out_data), 32'd15);
    chk("stream_cnt0", 32'(bus.count), 32'd0);
    tick();
    chk("stream_done_v", 32'(bus.out_valid), 32'd0);
    chk("stream_done_e", 32'(bus.empty), 32'd1);
    chk("stream_addr", 32'(bus.read_addr), 32'd1);
    bus.out_ready = 1'b0;

    // Simultaneous write and load at count 3.
    for (int i = 0; i < 4; i++) wr(8'h10 + 8'(i), 1'b1);
    chk("simul_pre_cnt", 32'(bus.count), 32'd3);
    chk("simul_pre_v", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    wr(8'h14, 1'b1);
    wr_idle();
    chk("simul_cnt", 32'(bus.count), 32'd3);
    drain("simul_drain", 20, 1'b0);

    // Overflow: fill memory plus output register, then one extra strobe.
    for (int i = 0; i < 17; i++) wr(8'h20 + 8'(i), 1'b1);
    wr_idle();
    chk("ovf_full_cnt", 32'(bus.count), 32'd16);
    chk("ovf_pre", 32'(bus.overflow), 32'd0);
    wr(8'hEE, 1'b0);
    wr_idle();
    chk("ovf_sat_cnt", 32'(bus.count), 32'd16);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    drain("ovf_drain", 40, 1'b0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Backpressure: six words with out_ready toggling.
    for (int i = 0; i < 6; i++) wr(8'h40 + 8'(i), 1'b1);
    wr_idle();
    chk("bp_cnt", 32'(bus.count), 32'd5);
    drain("bp_drain", 30, 1'b1);
    chk("bp_all_seen", 32'(exp_q.size()), 32'd0);

    // Mid-stream reset: valid drops at once, overflow clears.
    for (int i = 0; i < 3; i++) wr(8'h60 + 8'(i), 1'b1);
    wr_idle();
    chk("mrst_pre_v", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid_now", 32'(bus.out_valid), 32'd0);
    chk("mrst_ovf", 32'(bus.overflow), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_addr", 32'(bus.read_addr), 32'd0);
    chk("mrst_cnt", 32'(bus.count), 32'd0);
    chk("mrst_empty", 32'(bus.empty), 32'd1);
    chk("mrst_ovf_after", 32'(bus.overflow), 32'd0);
    wr(8'h77, 1'b1);
    wr_idle();
    drain("mrst_drain", 10, 1'b0);
    chk("mrst_post_addr", 32'(bus.read_addr), 32'd1);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
